// File: rtl/i2c_addr_xlate_mc_if.sv
// i2c_addr_xlate_mc_if: upstream SDA plus per-channel downstream SDA lines of the address translator
interface i2c_addr_xlate_mc_if #(parameter int NUM_CH = 4);
  logic SDA;
  logic SDA_US;
  logic [NUM_CH-1:0] SDA_DS_IN;
  logic [NUM_CH-1:0] SDA_DS;
  modport master(output SDA, SDA_DS_IN, input SDA_DS, SDA_US);
  modport slave(input SDA, SDA_DS_IN, output SDA_DS, SDA_US);
endinterface

// File: rtl/i2c_addr_xlate_mc.sv
// i2c_addr_xlate_mc: table-driven I2C address translator bridging one upstream bus to NUM_CH downstream channels
module i2c_addr_xlate_mc #(
  parameter int NUM_CH = 4,
  parameter int NUM_MAP = 4,
  parameter int MAX_BYTES = 16,
  parameter int CNT_W = 8,
  parameter int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    SCL,
  input  logic                    rst,
  i2c_addr_xlate_mc_if.slave      bus,
  input  logic [NUM_MAP*7-1:0]    MAP_VIRT,
  input  logic [NUM_MAP*7-1:0]    MAP_PHYS,
  input  logic [NUM_MAP*CH_W-1:0] MAP_CH,
  input  logic [NUM_MAP-1:0]      MAP_EN,
  output logic                    busy,
  output logic [CH_W-1:0]         active_ch,
  output logic [CNT_W-1:0]        miss_cnt
);
  localparam int BW = $clog2(MAX_BYTES + 1);
  localparam logic [BW-1:0] MAXB = BW'(MAX_BYTES);
  localparam logic [2:0] S_IDLE = 3'd0, S_ADDR = 3'd1, S_XLATE = 3'd2, S_AACK = 3'd3,
                         S_WDATA = 3'd4, S_RDATA = 3'd5, S_DACK = 3'd6, S_DROP = 3'd7;
  logic [2:0] r_st, w_nst, r_bit;
  logic [BW-1:0] r_bytes, w_bn;
  logic [6:0] r_sh, w_phys;
  logic [7:0] r_tx, w_dec;
  logic [CH_W-1:0] w_ch;
  logic [NUM_CH-1:0] w_ds;
  logic w_us, w_hit, w_lo, w_ack, w_dec_edge;
  always_comb begin
    w_dec = {r_sh, bus.SDA};
    w_lo = r_bit == 3'd7;
    w_dec_edge = (r_st == S_ADDR) && w_lo;
    w_bn = r_bytes + 1'b1;
    w_hit = 1'b0;
    w_phys = '0;
    w_ch = '0;
    for (int k = NUM_MAP - 1; k >= 0; k--)
      if (MAP_EN[k] && MAP_VIRT[7*k +: 7] == w_dec[7:1]) begin
        w_hit = 1'b1;
        w_phys = MAP_PHYS[7*k +: 7];
        w_ch = (NUM_CH > 1) ? MAP_CH[CH_W*k +: CH_W] : '0;
      end
    w_nst = r_st;
    w_ds = '1;
    w_us = 1'b1;
    w_ack = 1'b1;
    case (r_st)
      S_IDLE: w_nst = bus.SDA ? S_IDLE : S_ADDR;
      S_ADDR: w_nst = !w_lo ? S_ADDR : w_hit ? S_XLATE : S_DROP;
      S_XLATE: begin
        w_ds[active_ch] = r_tx[~r_bit];
        w_nst = w_lo ? S_AACK : S_XLATE;
      end
      S_AACK: begin
        w_us = bus.SDA_DS_IN[active_ch];
        w_nst = w_us ? S_IDLE : r_tx[0] ? S_RDATA : S_WDATA;
      end
      S_WDATA: begin
        w_ds[active_ch] = bus.SDA;
        w_nst = w_lo ? S_DACK : S_WDATA;
      end
      S_RDATA: begin
        w_us = bus.SDA_DS_IN[active_ch];
        w_nst = w_lo ? S_DACK : S_RDATA;
      end
      S_DACK: begin
        w_ack = r_tx[0] ? bus.SDA : bus.SDA_DS_IN[active_ch];
        if (r_tx[0]) w_ds[active_ch] = w_ack;
        else w_us = w_ack;
        w_nst = (w_ack || w_bn == MAXB) ? S_IDLE : r_tx[0] ? S_RDATA : S_WDATA;
      end
      default: w_nst = S_IDLE;
    endcase
    if (w_nst == S_IDLE) begin
      w_ds = '1;
      w_us = 1'b1;
    end
  end
  always_ff @(posedge SCL) begin
    if (!rst) begin
      r_st <= S_IDLE;
      r_bit <= '0;
      r_bytes <= '0;
      r_sh <= '0;
      r_tx <= '0;
      bus.SDA_DS <= '1;
      bus.SDA_US <= 1'b1;
      busy <= 1'b0;
      active_ch <= '0;
      miss_cnt <= '0;
    end else begin
      r_st <= w_nst;
      r_bit <= (r_st == S_IDLE || w_nst != r_st) ? '0 : r_bit + 3'd1;
      r_bytes <= (r_st == S_IDLE) ? '0 : (r_st == S_DACK) ? w_bn : r_bytes;
      r_sh <= {r_sh[5:0], bus.SDA};
      r_tx <= (w_dec_edge && w_hit) ? {w_phys, w_dec[0]} : r_tx;
      miss_cnt <= (w_dec_edge && !w_hit && !(&miss_cnt)) ? miss_cnt + 1'b1 : miss_cnt;
      active_ch <= (w_nst == S_IDLE) ? '0 : (w_dec_edge && w_hit) ? w_ch : active_ch;
      busy <= w_nst != S_IDLE;
      bus.SDA_DS <= w_ds;
      bus.SDA_US <= w_us;
    end
  end
endmodule

// File: doc/i2c_addr_xlate_mc.md
# i2c_addr_xlate_mc

Multi-channel, table-driven I2C address translator for the bus-bridging path. Captures the 7-bit address + R/W from the upstream bus, looks it up in a parametrised virtual→physical map, re-emits the translated address on the selected downstream channel, then forwards write data, read data and ACK/NACK in both directions for a bounded number of bytes. Unmatched addresses are NACKed and counted.

## Interface
- NUM_CH, 4: downstream channels (≥1); CH_W = max(1, clog2(NUM_CH))
- NUM_MAP, 4: map table entries (≥1)
- MAX_BYTES, 16: data bytes forwarded per transaction before forced return to IDLE (≥1)
- CNT_W, 8: miss counter width
- SCL  in  1  clock; all logic on posedge SCL
- rst  in  1  synchronous, active-low reset, sampled on posedge SCL
- SDA  in  1  upstream data from master
- SDA_DS_IN  in  NUM_CH  downstream return data (slave ACK / read data), bit i = channel i
- MAP_VIRT  in  NUM_MAP*7  virtual address of entry k at [7k+6:7k]
- MAP_PHYS  in  NUM_MAP*7  physical address of entry k
- MAP_CH  in  NUM_MAP*CH_W  target channel of entry k
- MAP_EN  in  NUM_MAP  entry enable
- SDA_DS  out  NUM_CH  downstream data, bit i = channel i
- SDA_US  out  1  upstream return data (ACK / read data) to master
- busy  out  1  high in every state except IDLE
- active_ch  out  CH_W  latched channel; 0 in IDLE
- miss_cnt  out  CNT_W  saturating count of unmatched addresses

## Operation
- All outputs registered. Idle level of every SDA_DS bit and SDA_US is 1; non-selected channels held at 1 at all times.
- States: IDLE, ADDR, XLATE, AACK, WDATA, RDATA, DACK, DROP.
- IDLE: SDA sampled 0 → ADDR; byte/bit counters cleared.
- ADDR: shift SDA into an 8-bit register MSB first for 8 edges. On the 8th edge, decode the complete byte (including the bit sampled on that edge): addr = bits[7:1], rw = bit[0].
- Lookup: lowest-index k with MAP_EN[k]=1 and MAP_VIRT[k]==addr wins. Hit → latch phys, channel, rw → XLATE. Miss → miss_cnt+1 (saturating at all-ones) → DROP.
- Table inputs are read only on the decode edge; later changes do not affect the current transaction.
- XLATE: 8 edges driving {phys, rw} MSB first onto SDA_DS[ch] → AACK.
- AACK (1 edge): SDA_DS[ch] ← 1; SDA_US ← SDA_DS_IN[ch]. Sample 1 (NACK) → IDLE; 0 → WDATA if rw=0, RDATA if rw=1.
- WDATA: 8 edges SDA_DS[ch] ← SDA → DACK; slave ACK: SDA_US ← SDA_DS_IN[ch].
- RDATA: 8 edges SDA_US ← SDA_DS_IN[ch] → DACK; master ACK: SDA_DS[ch] ← SDA, SDA_US ← 1.
- DACK: byte count +1. Ack bit 1, or byte count == MAX_BYTES → IDLE; else back to WDATA/RDATA.
- DROP (1 edge): SDA_US ← 1 (NACK), all SDA_DS ← 1 → IDLE.
- Entering IDLE from any state drives all SDA_DS bits and SDA_US to 1.

## Timing
- Reset (rst=0 at a posedge, any state): state IDLE, SDA_DS all 1, SDA_US 1, busy 0, active_ch 0, miss_cnt 0, counters 0. Takes priority over all other activity.
- Start detection at edge 0; address bits at edges 1–8; decode on edge 8.
- Hit: translated MSB visible on SDA_DS[ch] after edge 9; LSB (rw) after edge 16; AACK at edge 17.
- Miss: miss_cnt updates after edge 8; DROP at edge 9; IDLE from edge 10.
- Each data byte is 9 edges: 8 bit edges plus DACK. Per-bit latency is 1 SCL edge, registered, in both directions.
- busy rises after edge 0 and falls on the edge that enters IDLE.
- miss_cnt at all-ones stays there.
- NUM_CH=1: channel always 0. Duplicate enabled entries: lowest index wins.

## Test plan
- Map 0 = {0x21→0x48, ch 2}. Send 0x42 (0x21, write), slave ACK, bytes 0xA5, 0x3C → SDA_DS[2] carries 0x90, then 0xA5, 0x3C; SDA_US=0 in each ack slot; other channels stay 1; IDLE after MAX_BYTES or NACK.
- Send 0x43 (0x21, read), slave returns 0x5A, master NACK → SDA_US carries 0x5A; SDA_DS[2] carries the NACK bit; busy falls on the DACK edge.
- Send 0x50 (unmapped) three times → SDA_US=1 in each ack slot; miss_cnt=3; no SDA_DS activity. CNT_W=2, 5 misses → miss_cnt saturates at 3.
- Entries 0 and 3 both enabled with virt 0x22 (ch 1 / ch 3) → ch 1 used. Disable entry 0 → ch 3 used.
- Address-phase NACK (SDA_DS_IN[ch]=1) → IDLE after AACK. MAX_BYTES=2 with continuous ACKs → IDLE after the 2nd DACK.
- rst=0 during WDATA bit 4 → all SDA_DS, SDA_US = 1, busy 0, miss_cnt 0 on that edge. Change MAP_PHYS mid-XLATE → emitted address unchanged.
